// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - front-panel view/set-mode sequencer for the world clock
//   clk, reset            : 100 Hz system clock, synchronous active-high reset
//   btn_mode/adj/view     : raw asynchronous pushbuttons
//   sec_tick              : single-cycle 1 Hz strobe, drives the inactivity timeout
//   select                : display mux select, 0 = time, 1 = date
//   inc_hour .. inc_year  : single-cycle increment strobes to calendar / offset blocks
//   blink_mask            : per display pair blanking, bit3 = ss7/ss6 .. bit0 = ss1/ss0
//   setting               : high in any SET state

module cmc_debounce #(
  parameter int CYCLES = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int W = $clog2(CYCLES) + 1;

  logic         s1;
  logic         s2;
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // Any sample agreeing with the accepted level restarts the run.
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt >= W'(CYCLES - 1)) begin
        cnt   <= '0;
        level <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module clock_mode_controller #(
  parameter int DEBOUNCE_CYCLES = 5,
  parameter int REPEAT_DELAY    = 50,
  parameter int REPEAT_RATE     = 10,
  parameter int TIMEOUT_SECS    = 10,
  parameter int BLINK_HALF      = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_adj,
  input  logic       btn_view,
  input  logic       sec_tick,
  output logic       select,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_day,
  output logic       inc_month,
  output logic       inc_year,
  output logic [3:0] blink_mask,
  output logic       setting
);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX) + 1;
  localparam int IW      = $clog2(TIMEOUT_SECS) + 1;
  localparam int BW      = $clog2(BLINK_HALF) + 1;

  typedef enum logic [2:0] {
    SHOW_TIME = 3'd0,
    SHOW_DATE = 3'd1,
    SET_HOUR  = 3'd2,
    SET_MIN   = 3'd3,
    SET_MONTH = 3'd4,
    SET_DAY   = 3'd5,
    SET_YEAR  = 3'd6
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [2:0]    lvl;        // accepted levels: 0 = mode, 1 = adj, 2 = view
  logic [2:0]    lvl_q;
  logic [2:0]    press;
  logic          mode_p, adj_p, view_p;
  logic          in_set, next_in_set, next_sel, state_change, any_press;
  logic          timeout, rep_due, press_strobe, strobe;
  logic          rep_active, rep_fast;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_target;
  logic [IW-1:0] idle_cnt;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic          blink_phase, blink_phase_n;

  cmc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_mode (.clk(clk), .reset(reset), .raw(btn_mode), .level(lvl[0]));
  cmc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_adj  (.clk(clk), .reset(reset), .raw(btn_adj),  .level(lvl[1]));
  cmc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_view (.clk(clk), .reset(reset), .raw(btn_view), .level(lvl[2]));

  // Press pulses last exactly the cycle after the accepted level rises.
  assign press  = lvl & ~lvl_q;
  assign mode_p = press[0];
  assign adj_p  = press[1];
  assign view_p = press[2];

  function automatic logic [3:0] field_mask(input state_t s);
    case (s)
      SET_HOUR:  field_mask = 4'b1010;
      SET_MIN:   field_mask = 4'b0101;
      SET_MONTH: field_mask = 4'b1000;
      SET_DAY:   field_mask = 4'b0100;
      SET_YEAR:  field_mask = 4'b0011;
      default:   field_mask = 4'b0000;
    endcase
  endfunction

  always_comb begin
    in_set     = (state != SHOW_TIME) && (state != SHOW_DATE);
    any_press  = |press;
    rep_target = rep_fast ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);
    // mode wins over a held adj: the state moves on and no repeat strobe fires.
    rep_due    = in_set && rep_active && lvl[1] && !mode_p && (rep_cnt == rep_target);
    // Any press or repeat strobe in the same cycle keeps the user in the SET state.
    timeout    = in_set && sec_tick && !any_press && !rep_due &&
                 (idle_cnt >= IW'(TIMEOUT_SECS - 1));

    next_state = state;
    if (mode_p) begin
      case (state)
        SHOW_TIME, SHOW_DATE: next_state = SET_HOUR;
        SET_HOUR:             next_state = SET_MIN;
        SET_MIN:              next_state = SET_MONTH;
        SET_MONTH:            next_state = SET_DAY;
        SET_DAY:              next_state = SET_YEAR;
        default:              next_state = SHOW_TIME;
      endcase
    end else if (view_p && !in_set) begin
      next_state = (state == SHOW_TIME) ? SHOW_DATE : SHOW_TIME;
    end else if (timeout) begin
      next_state = SHOW_TIME;
    end

    state_change = (next_state != state);
    next_in_set  = (next_state != SHOW_TIME) && (next_state != SHOW_DATE);
    next_sel     = next_state inside {SHOW_DATE, SET_MONTH, SET_DAY, SET_YEAR};
    press_strobe = in_set && adj_p && !mode_p;
    strobe       = press_strobe || rep_due;

    // Restarting the blink on every edit keeps the changed field visible.
    if (state_change || strobe || !in_set) begin
      blink_cnt_n   = '0;
      blink_phase_n = 1'b0;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt_n   = '0;
      blink_phase_n = ~blink_phase;
    end else begin
      blink_cnt_n   = blink_cnt + 1'b1;
      blink_phase_n = blink_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SHOW_TIME;
      select      <= 1'b0;
      setting     <= 1'b0;
      blink_mask  <= 4'b0000;
      inc_hour    <= 1'b0;
      inc_min     <= 1'b0;
      inc_month   <= 1'b0;
      inc_day     <= 1'b0;
      inc_year    <= 1'b0;
      lvl_q       <= 3'b000;
      rep_active  <= 1'b0;
      rep_fast    <= 1'b0;
      rep_cnt     <= '0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= next_state;
      select      <= next_sel;
      setting     <= next_in_set;
      blink_mask  <= blink_phase_n ? field_mask(next_state) : 4'b0000;
      inc_hour    <= strobe && (state == SET_HOUR);
      inc_min     <= strobe && (state == SET_MIN);
      inc_month   <= strobe && (state == SET_MONTH);
      inc_day     <= strobe && (state == SET_DAY);
      inc_year    <= strobe && (state == SET_YEAR);
      lvl_q       <= lvl;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;

      // rep_cnt holds cycles since the last strobe; the first gap is the long one.
      if (press_strobe) begin
        rep_active <= 1'b1;
        rep_fast   <= 1'b0;
        rep_cnt    <= RW'(1);
      end else if (rep_active && lvl[1] && in_set && !state_change) begin
        if (rep_due) begin
          rep_fast <= 1'b1;
          rep_cnt  <= RW'(1);
        end else if (rep_cnt != '1) begin
          rep_cnt <= rep_cnt + 1'b1;
        end
      end else begin
        rep_active <= 1'b0;
        rep_fast   <= 1'b0;
        rep_cnt    <= '0;
      end

      if (!next_in_set || state_change || any_press || rep_due) begin
        idle_cnt <= '0;
      end else if (sec_tick && (idle_cnt != IW'(TIMEOUT_SECS))) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_clock_mode_controller.sv
// tb/tb_clock_mode_controller.sv - table, directed and random checks for clock_mode_controller

module tb_clock_mode_controller;
  localparam int DEB = 2, DELAY = 6, RATE = 3, TMO = 3, HALF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_adj = 1'b0, btn_view = 1'b0, sec_tick = 1'b0;
  logic       select, inc_hour, inc_min, inc_day, inc_month, inc_year, setting;
  logic [3:0] blink_mask;
  logic [4:0] dut_inc;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  clock_mode_controller #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DELAY), .REPEAT_RATE(RATE),
    .TIMEOUT_SECS(TMO), .BLINK_HALF(HALF)
  ) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_adj(btn_adj),
    .btn_view(btn_view), .sec_tick(sec_tick), .select(select),
    .inc_hour(inc_hour), .inc_min(inc_min), .inc_day(inc_day),
    .inc_month(inc_month), .inc_year(inc_year), .blink_mask(blink_mask),
    .setting(setting)
  );

  // {hour, min, month, day, year}
  assign dut_inc = {inc_hour, inc_min, inc_month, inc_day, inc_year};

  // Reference model. States: 0 show time, 1 show date, 2 hour, 3 min, 4 month, 5 day, 6 year.
  int         mode_next[7] = '{2, 2, 3, 4, 5, 6, 0};
  logic       sel_tab[7]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [3:0] mask_tab[7]  = '{4'b0000, 4'b0000, 4'b1010, 4'b0101, 4'b1000, 4'b0100, 4'b0011};
  logic [4:0] inc_tab[7]   = '{5'b00000, 5'b00000, 5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};

  int          m_state = 0;
  logic        m_sel = 0, m_set = 0;
  logic [3:0]  m_mask = 0;
  logic [4:0]  m_inc = 0;
  bit          rep_on = 0;
  int          rep_age = 0, idle = 0, blink_age = 0;
  logic [1:0]  hist[3];
  logic [31:0] sh[3];
  int          sh_n[3];
  bit          lvl[3], prs[3];

  logic [4:0] inc_seen;
  int         inc_cnt;
  int         day_q[$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_step();
    bit [2:0]    raw;
    bit          samp, in_set, anyp, due, pstrobe, strobe;
    int          k, nxt;
    logic [31:0] win;
    raw = {btn_view, btn_adj, btn_mode};
    win = (32'd1 << DEB) - 32'd1;
    if (reset) begin
      m_state = 0; m_sel = 0; m_set = 0; m_mask = 0; m_inc = 0;
      rep_on = 0; rep_age = 0; idle = 0; blink_age = 0;
      for (int b = 0; b < 3; b++) begin
        hist[b] = 2'b00; sh[b] = 0; sh_n[b] = 0; lvl[b] = 0; prs[b] = 0;
      end
      return;
    end
    // Control decisions use the press/level seen before this edge.
    in_set = m_state >= 2;
    anyp   = prs[0] | prs[1] | prs[2];
    k      = rep_age + 1;
    due    = in_set && rep_on && lvl[1] && !prs[0] &&
             (k == DELAY || (k > DELAY && (k - DELAY) % RATE == 0));
    nxt = m_state;
    if (prs[0]) nxt = mode_next[m_state];
    else if (prs[2] && !in_set) nxt = 1 - m_state;
    else if (in_set && sec_tick && !anyp && !due && idle + 1 >= TMO) nxt = 0;
    pstrobe = in_set && prs[1] && !prs[0];
    strobe  = pstrobe || due;
    m_inc   = strobe ? inc_tab[m_state] : 5'b00000;
    if (pstrobe) begin
      rep_on = 1; rep_age = 0;
    end else if (rep_on && lvl[1] && in_set && nxt == m_state) begin
      rep_age = k;
    end else begin
      rep_on = 0; rep_age = 0;
    end
    if (nxt < 2 || nxt != m_state || anyp || due) idle = 0;
    else if (sec_tick && idle < TMO) idle++;
    if (nxt != m_state || strobe || nxt < 2) blink_age = 0;
    else blink_age++;
    m_state = nxt;
    m_sel   = sel_tab[nxt];
    m_set   = nxt >= 2;
    m_mask  = ((blink_age / HALF) % 2 == 1) ? mask_tab[nxt] : 4'b0000;
    // Button conditioning: two-sample delay, then DEB consecutive disagreeing samples.
    for (int b = 0; b < 3; b++) begin
      samp    = hist[b][1];
      hist[b] = {hist[b][0], raw[b]};
      prs[b]  = 0;
      sh[b]   = {sh[b][30:0], samp};
      if (sh_n[b] < 32) sh_n[b]++;
      if (sh_n[b] >= DEB && ((sh[b] & win) == (lvl[b] ? 32'd0 : win))) begin
        lvl[b] = samp; prs[b] = samp; sh_n[b] = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
    check("model", {5'b0, select, setting, blink_mask, dut_inc},
          {5'b0, m_sel, m_set, m_mask, m_inc});
    inc_seen |= dut_inc;
    inc_cnt  += $countones(dut_inc);
    if (inc_day) day_q.push_back(cyc_n);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic set_btns(input bit [2:0] v);
    btn_mode = v[0]; btn_adj = v[1]; btn_view = v[2];
  endtask

  task automatic press(input bit [2:0] v, input int hold, input int gap);
    set_btns(v); run(hold);
    set_btns(3'b000); run(gap);
  endtask

  task automatic tick();
    sec_tick = 1'b1; cyc(); sec_tick = 1'b0;
  endtask

  task automatic do_reset();
    set_btns(3'b000); sec_tick = 1'b0; reset = 1'b1;
    run(2);
    check("reset_outputs", {select, setting, blink_mask, dut_inc}, 11'd0);
    reset = 1'b0;
  endtask

  typedef struct {
    bit [2:0] btns;
    bit       exp_sel;
    bit       exp_set;
    bit [4:0] exp_inc;
    int       exp_cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit [2:0] b, input bit s, input bit st, input bit [4:0] inc, input int n);
    vec_t v;
    v.btns = b; v.exp_sel = s; v.exp_set = st; v.exp_inc = inc; v.exp_cnt = n;
    tbl.push_back(v);
  endtask

  int rep_off[6] = '{0, 6, 9, 12, 15, 18};

  initial begin
    // buttons {view, adj, mode}
    add(3'b100, 1, 0, 5'b00000, 0);  // show date
    add(3'b100, 0, 0, 5'b00000, 0);  // show time
    add(3'b001, 0, 1, 5'b00000, 0);  // set hour
    add(3'b100, 0, 1, 5'b00000, 0);  // view ignored
    add(3'b001, 0, 1, 5'b00000, 0);  // set min
    add(3'b001, 1, 1, 5'b00000, 0);  // set month
    add(3'b001, 1, 1, 5'b00000, 0);  // set day
    add(3'b001, 1, 1, 5'b00000, 0);  // set year
    add(3'b001, 0, 0, 5'b00000, 0);  // show time
    add(3'b010, 0, 0, 5'b00000, 0);  // adj ignored
    add(3'b100, 1, 0, 5'b00000, 0);  // show date
    add(3'b001, 0, 1, 5'b00000, 0);  // set hour from date view
    add(3'b010, 0, 1, 5'b10000, 1);  // inc_hour
    add(3'b011, 0, 1, 5'b00000, 0);  // mode beats adj -> set min
    add(3'b010, 0, 1, 5'b01000, 1);  // inc_min
    add(3'b001, 1, 1, 5'b00000, 0);  // set month
    add(3'b010, 1, 1, 5'b00100, 1);  // inc_month
    add(3'b001, 1, 1, 5'b00000, 0);  // set day
    add(3'b010, 1, 1, 5'b00010, 1);  // inc_day
    add(3'b001, 1, 1, 5'b00000, 0);  // set year
    add(3'b010, 1, 1, 5'b00001, 1);  // inc_year
    add(3'b001, 0, 0, 5'b00000, 0);  // show time
    add(3'b101, 0, 1, 5'b00000, 0);  // mode beats view -> set hour

    inc_seen = 0; inc_cnt = 0;

    // Reset, then view press latency and toggle back.
    do_reset();
    btn_view = 1'b1;
    run(4);
    check("view_before_latency", {15'd0, select}, 16'd0);
    run(1);
    check("view_latency", {15'd0, select}, 16'd1);
    run(5);
    btn_view = 1'b0;
    run(8);
    press(3'b100, 10, 8);
    check("view_toggle_back", {15'd0, select}, 16'd0);

    // Glitch rejection, then SET_HOUR entry with blink timing.
    press(3'b001, 1, 8);
    check("glitch_rejected", {15'd0, setting}, 16'd0);
    btn_mode = 1'b1;
    run(4);
    check("mode_before_latency", {15'd0, setting}, 16'd0);
    for (int k = 0; k < 12; k++) begin
      run(1);
      if (k == 0) check("enter_set_hour", {14'd0, select, setting}, 16'd1);
      check("blink_phase", {12'd0, blink_mask}, ((k / 4) % 2 == 1) ? 16'b1010 : 16'd0);
    end
    btn_mode = 1'b0;
    run(8);

    // Table of single presses.
    do_reset();
    foreach (tbl[i]) begin
      inc_seen = 0; inc_cnt = 0;
      press(tbl[i].btns, 4, 4);
      check($sformatf("vec%0d_view", i), {14'd0, select, setting}, {14'd0, tbl[i].exp_sel, tbl[i].exp_set});
      check($sformatf("vec%0d_inc", i), {inc_seen, 11'(inc_cnt)}, {tbl[i].exp_inc, 11'(tbl[i].exp_cnt)});
    end

    // Auto-repeat in SET_DAY.
    do_reset();
    repeat (4) press(3'b001, 4, 4);
    check("in_set_day", {14'd0, select, setting}, 16'b11);
    inc_seen = 0; inc_cnt = 0; day_q.delete();
    btn_adj = 1'b1;
    run(20);
    btn_adj = 1'b0;
    run(10);
    check("repeat_count", 16'(day_q.size()), 16'd6);
    for (int i = 1; i < 6; i++)
      if (i < day_q.size()) check($sformatf("repeat_offset%0d", i), 16'(day_q[i] - day_q[0]), 16'(rep_off[i]));
    check("repeat_only_day", {11'd0, inc_seen}, 16'b00010);

    // Timeout from SET_MIN.
    do_reset();
    repeat (2) press(3'b001, 4, 4);
    run(3); tick(); run(3); tick(); run(3);
    check("before_timeout", {14'd0, select, setting}, 16'b01);
    tick();
    check("timeout_exit", {14'd0, select, setting}, 16'b00);
    repeat (2) press(3'b001, 4, 4);
    tick(); run(2); tick(); run(2);
    press(3'b010, 4, 4);
    tick(); run(2); tick(); run(2);
    check("idle_cleared_by_adj", {14'd0, select, setting}, 16'b01);
    tick();
    check("timeout_after_adj", {14'd0, select, setting}, 16'b00);
    repeat (2) press(3'b001, 4, 4);
    tick(); run(2); tick(); run(2);
    btn_view = 1'b1;
    run(4);
    tick();
    check("press_beats_timeout", {14'd0, select, setting}, 16'b01);
    btn_view = 1'b0;
    run(8);

    // Reset in the middle of auto-repeat on inc_year.
    do_reset();
    repeat (5) press(3'b001, 4, 4);
    inc_seen = 0; inc_cnt = 0;
    btn_adj = 1'b1;
    run(13);
    check("repeat_before_reset", {inc_seen, 11'(inc_cnt)}, {5'b00001, 11'd2});
    reset = 1'b1;
    cyc();
    check("reset_abort", {select, setting, blink_mask, dut_inc}, 11'd0);
    reset = 1'b0;
    inc_seen = 0; inc_cnt = 0;
    run(20);
    btn_adj = 1'b0;
    run(8);
    check("no_strobe_after_reset", {inc_seen, 11'(inc_cnt)}, 16'd0);

    // Random stimulus against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0)  btn_mode = ~btn_mode;
      if ($urandom_range(0, 11) == 0) btn_adj  = ~btn_adj;
      if ($urandom_range(0, 7) == 0)  btn_view = ~btn_view;
      sec_tick = ($urandom_range(0, 9) == 0);
      reset    = ($urandom_range(0, 399) == 0);
      cyc();
    end
    reset = 1'b0; sec_tick = 1'b0; set_btns(3'b000);
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_mode_controller.md
Name: clock_mode_controller

Overview:
- Front-panel sequencer for the world clock: turns raw pushbuttons into a view/set-mode state machine.
- Drives the display mux select, issues single-cycle increment strobes to the calendar and offset-adjust blocks, and produces a blink mask for the field being edited.
- Sits between the raw pb inputs and the calendar, changeClock and muxModule instances; runs on the 100 Hz system clock and uses the 1 Hz strobe for its inactivity timeout.

Parameters:
- DEBOUNCE_CYCLES, 5: consecutive stable samples required before a button level is accepted.
- REPEAT_DELAY, 50: cycles btn_adj must be held after its first strobe before auto-repeat starts.
- REPEAT_RATE, 10: cycles between auto-repeat strobes.
- TIMEOUT_SECS, 10: sec_tick pulses with no accepted press before a SET state exits.
- BLINK_HALF, 50: cycles per blink half-period.

Ports:
- clk  input  1  system clock, 100 Hz
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where it is high
- btn_mode  input  1  raw, asynchronous; enter/advance set mode
- btn_adj  input  1  raw, asynchronous; increment the selected field
- btn_view  input  1  raw, asynchronous; toggle time/date view in show states
- sec_tick  input  1  single-cycle 1 Hz strobe
- select  output  1  0 = time view, 1 = date view
- inc_hour, inc_min, inc_day, inc_month, inc_year  output  1 each  single-cycle increment strobes
- blink_mask  output  4  per display pair, bit3 = ss7/ss6 ... bit0 = ss1/ss0; 1 = blank this pair
- setting  output  1  high in any SET state

Behaviour:
- Input conditioning:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - Debouncer: the accepted level changes only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current accepted level. Any matching sample clears the counter.
  - A press event is a single-cycle pulse on the 0->1 edge of the accepted level.
  - Raw-to-press latency: 2 + DEBOUNCE_CYCLES cycles.
- States and outputs:
  - SHOW_TIME: select=0.
  - SHOW_DATE: select=1.
  - SET_HOUR: select=0, mask 1010.
  - SET_MIN: select=0, mask 0101.
  - SET_MONTH: select=1, mask 1000.
  - SET_DAY: select=1, mask 0100.
  - SET_YEAR: select=1, mask 0011.
- Transitions:
  - SHOW_TIME <-> SHOW_DATE on a view press.
  - A mode press in either show state enters SET_HOUR.
  - Each further mode press advances SET_HOUR -> SET_MIN -> SET_MONTH -> SET_DAY -> SET_YEAR -> SHOW_TIME.
  - view presses are ignored in SET states.
  - adj presses are ignored in show states.
- Increment strobes:
  - In a SET state, an adj press asserts the matching inc_* for exactly one cycle, registered, one cycle after the press pulse.
  - At most one inc_* is high in any cycle.
- Auto-repeat:
  - While the accepted adj level stays high in a SET state, a counter starts at the first strobe.
  - At REPEAT_DELAY cycles it issues a strobe, then one every REPEAT_RATE cycles.
  - Release, or any state change, stops auto-repeat and clears the counter.
- Blink:
  - blink_mask = state mask while blink_phase=1, else 0000.
  - blink_phase starts at 0 and toggles every BLINK_HALF cycles.
  - The phase and its counter reset to 0 on SET-state entry and on every inc strobe, so the edited field is visible immediately after a change.
  - blink_mask is 0000 in show states.
- Timeout:
  - The idle counter increments on sec_tick in SET states.
  - It clears on any accepted press (mode, adj or view) and on state entry.
  - When it reaches TIMEOUT_SECS the FSM goes to SHOW_TIME.
  - Auto-repeat strobes also clear the idle counter.
- Simultaneous events, same cycle:
  - mode beats adj: state advances, no strobe.
  - mode beats view.
  - A timeout coinciding with a press: the press wins and the counter clears.
- Reset:
  - select=0, all inc_*=0, blink_mask=0000, setting=0, state SHOW_TIME.
  - Debounce, repeat, blink and idle counters are cleared; accepted button levels are cleared to 0.
  - Asserting reset mid-repeat or mid-edit aborts with no further strobes.
- Widths: each counter is sized with $clog2 of its parameter + 1; all counters saturate, none wrap.

Test Plan:
- Use DEBOUNCE_CYCLES=2, REPEAT_DELAY=6, REPEAT_RATE=3, TIMEOUT_SECS=3, BLINK_HALF=4 for all scenarios.
- Reset then idle: select=0, setting=0, blink_mask=0000, all inc_*=0. btn_view high 10 cycles -> select=1 at cycle 5 after assertion. Release, press again -> select=0.
- Glitch rejection: btn_mode high for 1 cycle, then low -> no state change. Held high 10 cycles -> SET_HOUR, setting=1, blink_mask 0000 for 4 cycles then 1010, alternating every 4 cycles.
- Full mode cycle: 6 clean mode presses from SHOW_TIME -> states SET_HOUR, SET_MIN, SET_MONTH, SET_DAY, SET_YEAR, SHOW_TIME. select = 0, 0, 1, 1, 1, 0. No inc_* pulses.
- Auto-repeat in SET_DAY: hold btn_adj 20 cycles past debounce -> inc_day pulses at offsets 0, 6, 9, 12, 15, 18. inc_day is 1 cycle wide each time, and no other inc_* ever asserts.
- Timeout: enter SET_MIN, no presses, 3 sec_tick pulses -> SHOW_TIME on the cycle after the third. Repeat with an adj press after 2 ticks -> still SET_MIN after 4 ticks total.
- Conflicts/reset:
  - mode and adj accepted the same cycle in SET_HOUR -> SET_MIN, no inc_hour.
  - reset asserted while auto-repeating inc_year -> next cycle SHOW_TIME, no further strobes.
